// File: rtl/input_debounce_if.sv
// rtl/input_debounce_if.sv - raw input and conditioned outputs of the debounce stage
//
// Signals:
//   a      raw asynchronous input level (driven by the board/source side)
//   y      debounced, synchronised level
//   rise   one-cycle strobe on y 0->1
//   fall   one-cycle strobe on y 1->0
//   toggle level that flips on every rise
//   busy   high while a candidate transition is being qualified
// Modports:
//   master - source/consumer side: drives a, observes the outputs
//   slave  - the debounce block: samples a, drives the outputs
interface input_debounce_if;
    logic a;
    logic y;
    logic rise;
    logic fall;
    logic toggle;
    logic busy;

    modport master (
        output a,
        input  y,
        input  rise,
        input  fall,
        input  toggle,
        input  busy
    );

    modport slave (
        input  a,
        output y,
        output rise,
        output fall,
        output toggle,
        output busy
    );
endinterface

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - two-flop synchroniser plus counting debounce FSM with edge strobes
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   bus    input_debounce_if.slave: a in; y, rise, fall, toggle, busy out
// Parameters:
//   STABLE_CYCLES  consecutive synchronised samples of a new level needed before y moves (2..65535)
//   CNT_W          qualification counter width, 2**CNT_W > STABLE_CYCLES
module input_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input_debounce_if.slave   bus
);
    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1;
    logic             s2;
    logic             y_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic             toggle_reg;
    logic             busy_reg;

    // The first sample of a new level is taken on entry to CHK_*, so cnt starts
    // at 1 and the transition completes when cnt has reached STABLE_CYCLES-1 and
    // one more matching sample arrives; a single reversion drops back to the
    // stable state with the count discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            cnt        <= '0;
            state      <= LOW;
            y_reg      <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            toggle_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            s1       <= bus.a;
            s2       <= s1;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (state)
                LOW: begin
                    if (s2) begin
                        state    <= CHK_HI;
                        cnt      <= CNT_W'(1);
                        busy_reg <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                CHK_HI: begin
                    if (!s2) begin
                        state    <= LOW;
                        cnt      <= '0;
                        busy_reg <= 1'b0;
                    end else if (cnt == LAST) begin
                        state      <= HIGH;
                        cnt        <= '0;
                        busy_reg   <= 1'b0;
                        y_reg      <= 1'b1;
                        rise_reg   <= 1'b1;
                        toggle_reg <= ~toggle_reg;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state    <= CHK_LO;
                        cnt      <= CNT_W'(1);
                        busy_reg <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                CHK_LO: begin
                    if (s2) begin
                        state    <= HIGH;
                        cnt      <= '0;
                        busy_reg <= 1'b0;
                    end else if (cnt == LAST) begin
                        state    <= LOW;
                        cnt      <= '0;
                        busy_reg <= 1'b0;
                        y_reg    <= 1'b0;
                        fall_reg <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= LOW;
                    cnt      <= '0;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.y      = y_reg;
    assign bus.rise   = rise_reg;
    assign bus.fall   = fall_reg;
    assign bus.toggle = toggle_reg;
    assign bus.busy   = busy_reg;
endmodule

// File: tb/tb_input_debounce.sv
// tb/tb_input_debounce.sv - directed vector bench for input_debounce
module tb_input_debounce;
    logic clk;
    logic rst_n;

    input_debounce_if bus ();

    input_debounce #(
        .STABLE_CYCLES (4),
        .CNT_W         (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {y, rise, fall, toggle, busy}
    typedef struct packed {
        logic       a;
        logic       rst_n;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    function automatic void add(input logic ai, input logic ri, input logic y, input logic r,
                                input logic f, input logic t, input logic b);
        vec_t v;
        v.a     = ai;
        v.rst_n = ri;
        v.exp   = {y, r, f, t, b};
        vecs.push_back(v);
    endfunction

    function automatic logic [4:0] outs();
        return {bus.y, bus.rise, bus.fall, bus.toggle, bus.busy};
    endfunction

    task automatic step(input logic ai, input logic ri);
        bus.a = ai;
        rst_n = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Expected fall of y from HIGH with toggle t, a=0 held for 7 edges.
    function automatic void add_fall(input logic t);
        add(0, 1, 1, 0, 0, t, 0);
        add(0, 1, 1, 0, 0, t, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, t, 1);
        add(0, 1, 0, 0, 1, t, 0);
        add(0, 1, 0, 0, 0, t, 0);
    endfunction

    // Expected rise from LOW with toggle t before the rise, a=1 held for 7 edges.
    function automatic void add_rise(input logic t);
        add(1, 1, 0, 0, 0, t, 0);
        add(1, 1, 0, 0, 0, t, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, t, 1);
        add(1, 1, 1, 1, 0, ~t, 0);
        add(1, 1, 1, 0, 0, ~t, 0);
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        bus.a = 1'b0;
        rst_n = 1'b0;

        // Reset held with a=1, then release and qualify the high level.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0);
        add_rise(1'b0);
        // Clean release: fall at 6th edge, toggle stays 1.
        add_fall(1'b1);
        // Glitch: a=1 for 3 edges then 0.
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 1, 0);
        // Reset while in CHK_HI at edge 4, released with a=1.
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0);
        add_rise(1'b0);
        add_fall(1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].a, vecs[i].rst_n);
            check($sformatf("vec%0d_{y,rise,fall,tog,busy}", i), int'(outs()), int'(vecs[i].exp));
        end

        // Bounce: 1,1,0,1,0 then 1 held; final 0->1 is sampled at edge 6, y rises at edge 11.
        begin
            logic pat[0:4];
            int   rises;
            pat   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            rises = 0;
            for (int e = 1; e <= 13; e++) begin
                step((e <= 5) ? pat[e-1] : 1'b1, 1'b1);
                if (bus.rise) rises++;
                check($sformatf("bounce_y_e%0d", e), int'(bus.y), (e >= 11) ? 1 : 0);
            end
            check("bounce_rise_count", rises, 1);
            check("bounce_toggle", int'(bus.toggle), 0);
            for (int e = 0; e < 8; e++) step(1'b0, 1'b1);
            check("bounce_release_y", int'(bus.y), 0);
        end

        // Toggle sequence after a fresh reset: three press/release pairs.
        begin
            int rises;
            int falls;
            int both;
            logic exp_t[0:2];
            exp_t = '{1'b1, 1'b0, 1'b1};
            rises = 0;
            falls = 0;
            both  = 0;
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            check("toggle_after_reset", int'(bus.toggle), 0);
            for (int p = 0; p < 3; p++) begin
                for (int e = 0; e < 8; e++) begin
                    step(1'b1, 1'b1);
                    if (bus.rise) rises++;
                    if (bus.fall) falls++;
                    if (bus.rise && bus.fall) both++;
                end
                check($sformatf("toggle_press%0d", p), int'(bus.toggle), int'(exp_t[p]));
                for (int e = 0; e < 8; e++) begin
                    step(1'b0, 1'b1);
                    if (bus.rise) rises++;
                    if (bus.fall) falls++;
                    if (bus.rise && bus.fall) both++;
                end
                check($sformatf("toggle_release%0d", p), int'(bus.toggle), int'(exp_t[p]));
            end
            check("toggle_rise_count", rises, 3);
            check("toggle_fall_count", falls, 3);
            check("toggle_both_strobes", both, 0);
        end

        // Steady input: nothing moves.
        begin
            int changes;
            changes = 0;
            for (int e = 0; e < 20; e++) begin
                step(1'b0, 1'b1);
                if (outs() != 5'b00010) changes++;
            end
            check("steady_no_change", changes, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
